// File: rtl/dp_issue_if.sv
// dp_issue_if: instruction handshake, ALU drive/return, retire and debug signals of dp_issue.
interface dp_issue_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  instr_valid;
  logic [31:0]           instr;
  logic                  instr_ready;

  logic                  alu_enable;
  logic [3:0]            alu_opcode;
  logic [DATA_WIDTH-1:0] alu_operand1;
  logic [DATA_WIDTH-1:0] alu_operand2;
  logic                  alu_carry_in;
  logic                  alu_flag_update;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_n;
  logic                  alu_z;
  logic                  alu_c;
  logic                  alu_v;

  logic [3:0]            cpsr_flags;
  logic                  retire_valid;
  logic                  retire_executed;
  logic                  illegal;

  logic [3:0]            dbg_addr;
  logic [DATA_WIDTH-1:0] dbg_data;

  // Issue-unit side
  modport slave (
    input  instr_valid, instr, alu_result, alu_n, alu_z, alu_c, alu_v, dbg_addr,
    output instr_ready, alu_enable, alu_opcode, alu_operand1, alu_operand2,
           alu_carry_in, alu_flag_update, cpsr_flags, retire_valid,
           retire_executed, illegal, dbg_data
  );

  // Fetch / ALU / debug side
  modport master (
    output instr_valid, instr, alu_result, alu_n, alu_z, alu_c, alu_v, dbg_addr,
    input  instr_ready, alu_enable, alu_opcode, alu_operand1, alu_operand2,
           alu_carry_in, alu_flag_update, cpsr_flags, retire_valid,
           retire_executed, illegal, dbg_data
  );
endinterface

// File: rtl/dp_issue.sv
// dp_issue: sequences ARM-style data-processing instructions through the alu
// block and commits Rd and the CPSR flags. One instruction in flight at a time.
module dp_issue #(
  parameter int DATA_WIDTH = 32
) (
  input logic      clk,
  input logic      rst_n,
  dp_issue_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

  state_t                state_q, state_d;
  logic [31:0]           instr_q, instr_d;
  logic [DATA_WIDTH-1:0] regs_q [16];
  logic [DATA_WIDTH-1:0] regs_d [16];
  logic [3:0]            cpsr_q, cpsr_d;
  logic [3:0]            alu_opcode_q, alu_opcode_d;
  logic [DATA_WIDTH-1:0] alu_operand1_q, alu_operand1_d;
  logic [DATA_WIDTH-1:0] alu_operand2_q, alu_operand2_d;
  logic                  alu_carry_in_q, alu_carry_in_d;
  logic                  alu_flag_update_q, alu_flag_update_d;
  logic                  executed_q, executed_d;
  logic                  illegal_q, illegal_d;

  // Decoded fields of the latched instruction
  logic [3:0]            cond;
  logic                  imm_bit;
  logic [3:0]            opcode;
  logic                  s_bit;
  logic [3:0]            rn;
  logic [3:0]            rd;
  logic [3:0]            rm;
  logic [3:0]            rot;
  logic                  is_logical;
  logic                  writes_rd;
  logic                  illegal_enc;
  logic                  cond_ok;
  logic [31:0]           rot_amt;
  logic [DATA_WIDTH-1:0] imm_ext;
  logic [DATA_WIDTH-1:0] imm_rot;
  logic [DATA_WIDTH-1:0] shifter_op;
  logic                  shifter_carry;

  // ARM condition codes evaluated against {N,Z,C,V}
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'h0:    cond_pass = z;
      4'h1:    cond_pass = !z;
      4'h2:    cond_pass = cf;
      4'h3:    cond_pass = !cf;
      4'h4:    cond_pass = n;
      4'h5:    cond_pass = !n;
      4'h6:    cond_pass = v;
      4'h7:    cond_pass = !v;
      4'h8:    cond_pass = cf && !z;
      4'h9:    cond_pass = !cf || z;
      4'hA:    cond_pass = (n == v);
      4'hB:    cond_pass = (n != v);
      4'hC:    cond_pass = !z && (n == v);
      4'hD:    cond_pass = z || (n != v);
      4'hE:    cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  // Field extraction, legality, condition and shifter operand for the latched instruction
  always_comb begin
    cond    = instr_q[31:28];
    imm_bit = instr_q[25];
    opcode  = instr_q[24:21];
    s_bit   = instr_q[20];
    rn      = instr_q[19:16];
    rd      = instr_q[15:12];
    rm      = instr_q[3:0];
    rot     = instr_q[11:8];

    case (opcode)
      4'h0, 4'h1, 4'h8, 4'h9, 4'hC, 4'hD, 4'hE, 4'hF: is_logical = 1'b1;
      default:                                         is_logical = 1'b0;
    endcase
    writes_rd = (opcode[3:2] != 2'b10);

    illegal_enc = (instr_q[27:26] != 2'b00)
                | (cond == 4'hF)
                | (!imm_bit && (instr_q[11:4] != 8'h00))
                | ((opcode[3:2] == 2'b10) && !s_bit);
    cond_ok = cond_pass(cond, cpsr_q);

    rot_amt = {27'd0, rot, 1'b0} % DATA_WIDTH;
    imm_ext = DATA_WIDTH'(instr_q[7:0]);
    imm_rot = (imm_ext >> rot_amt) | (imm_ext << (32'(DATA_WIDTH) - rot_amt));

    shifter_op    = imm_bit ? imm_rot : regs_q[rm];
    shifter_carry = (imm_bit && (rot != 4'h0)) ? imm_rot[DATA_WIDTH-1] : cpsr_q[1];
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: decode skips EXEC for illegal or condition-failed instructions
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.instr_valid) state_d = DECODE;
      DECODE:  state_d = (!illegal_enc && cond_ok) ? EXEC : WB;
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs decoded from the current state
  always_comb begin
    bus.instr_ready     = (state_q == IDLE);
    bus.alu_enable      = (state_q == EXEC);
    bus.retire_valid    = (state_q == WB);
    bus.retire_executed = (state_q == WB) && executed_q;
    bus.illegal         = (state_q == WB) && illegal_q;
  end

  // Instruction latch and registered ALU drive, loaded as the instruction leaves DECODE
  always_comb begin
    instr_d           = instr_q;
    alu_opcode_d      = alu_opcode_q;
    alu_operand1_d    = alu_operand1_q;
    alu_operand2_d    = alu_operand2_q;
    alu_carry_in_d    = alu_carry_in_q;
    alu_flag_update_d = alu_flag_update_q;
    executed_d        = executed_q;
    illegal_d         = illegal_q;
    if (state_q == IDLE && bus.instr_valid) begin
      instr_d = bus.instr;
    end
    if (state_q == DECODE) begin
      executed_d = !illegal_enc && cond_ok;
      illegal_d  = illegal_enc;
      if (!illegal_enc && cond_ok) begin
        alu_opcode_d      = opcode;
        alu_operand1_d    = regs_q[rn];
        alu_operand2_d    = shifter_op;
        alu_carry_in_d    = is_logical ? shifter_carry : cpsr_q[1];
        alu_flag_update_d = s_bit;
      end
    end
  end

  // Rd and CPSR commit from the ALU return at the end of EXEC; logical ops keep V
  always_comb begin
    regs_d = regs_q;
    cpsr_d = cpsr_q;
    if (state_q == EXEC) begin
      if (writes_rd) regs_d[rd] = bus.alu_result;
      if (s_bit) cpsr_d = {bus.alu_n, bus.alu_z, bus.alu_c, is_logical ? cpsr_q[0] : bus.alu_v};
    end
  end

  // Datapath, register file and CPSR registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q           <= '0;
      alu_opcode_q      <= '0;
      alu_operand1_q    <= '0;
      alu_operand2_q    <= '0;
      alu_carry_in_q    <= 1'b0;
      alu_flag_update_q <= 1'b0;
      executed_q        <= 1'b0;
      illegal_q         <= 1'b0;
      cpsr_q            <= '0;
      for (int i = 0; i < 16; i++) regs_q[i] <= '0;
    end else begin
      instr_q           <= instr_d;
      alu_opcode_q      <= alu_opcode_d;
      alu_operand1_q    <= alu_operand1_d;
      alu_operand2_q    <= alu_operand2_d;
      alu_carry_in_q    <= alu_carry_in_d;
      alu_flag_update_q <= alu_flag_update_d;
      executed_q        <= executed_d;
      illegal_q         <= illegal_d;
      cpsr_q            <= cpsr_d;
      regs_q            <= regs_d;
    end
  end

  assign bus.alu_opcode      = alu_opcode_q;
  assign bus.alu_operand1    = alu_operand1_q;
  assign bus.alu_operand2    = alu_operand2_q;
  assign bus.alu_carry_in    = alu_carry_in_q;
  assign bus.alu_flag_update = alu_flag_update_q;
  assign bus.cpsr_flags      = cpsr_q;
  assign bus.dbg_data        = regs_q[bus.dbg_addr];

endmodule

// File: tb/tb_dp_issue.sv
// tb_dp_issue: drives dp_issue with directed and random instructions, plays the
// alu block, and checks every cycle against a per-instruction reference model.
module tb_dp_issue;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  dp_issue_if #(.DATA_WIDTH(32)) bus ();

  dp_issue #(.DATA_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs for one cycle, plus the architectural commit at its end
  typedef struct {
    bit          ready;
    bit          en;
    bit          rv;
    bit          rexec;
    bit          rill;
    logic [3:0]  op;
    logic [31:0] op1;
    logic [31:0] op2;
    bit          cin;
    bit          fu;
    bit          wr_rd;
    logic [3:0]  rd;
    logic [31:0] rd_val;
    bit          wr_cpsr;
    logic [3:0]  cpsr_val;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m_regs [16];
  logic [3:0]  m_cpsr;
  logic        v_junk;
  logic [35:0] alu_out;
  int          en_cnt, rv_cnt, ex_cnt, ill_cnt;

  function automatic exp_t idle_rec();
    exp_t e;
    e = '{ready: 1'b1, en: 1'b0, rv: 1'b0, rexec: 1'b0, rill: 1'b0, op: 4'h0,
          op1: 32'h0, op2: 32'h0, cin: 1'b0, fu: 1'b0, wr_rd: 1'b0, rd: 4'h0,
          rd_val: 32'h0, wr_cpsr: 1'b0, cpsr_val: 4'h0};
    return e;
  endfunction

  // Behavioural ARM ALU: {N,Z,C,V,result}; logical ops pass carry in and leave V undriven
  function automatic logic [35:0] alu_eval(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic cin, input logic vj);
    logic [32:0] s;
    logic [31:0] x, y, r;
    logic        ci, lg, c, v;
    lg = 1'b0; x = a; y = b; ci = 1'b0;
    case (op)
      4'h2, 4'hA: begin y = ~b; ci = 1'b1; end
      4'h3:       begin x = b; y = ~a; ci = 1'b1; end
      4'h4, 4'hB: ci = 1'b0;
      4'h5:       ci = cin;
      4'h6:       begin y = ~b; ci = cin; end
      4'h7:       begin x = b; y = ~a; ci = cin; end
      default:    lg = 1'b1;
    endcase
    s = {1'b0, x} + {1'b0, y} + 33'(ci);
    if (lg) begin
      case (op)
        4'h0, 4'h8: r = a & b;
        4'h1, 4'h9: r = a ^ b;
        4'hC:       r = a | b;
        4'hD:       r = b;
        4'hE:       r = a & ~b;
        default:    r = ~b;
      endcase
      c = cin;
      v = vj;
    end else begin
      r = s[31:0];
      c = s[32];
      v = (x[31] == y[31]) && (r[31] != x[31]);
    end
    return {r[31], (r == 32'h0), c, v, r};
  endfunction

  function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cf, v;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cf;
      4'h3: return !cf;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cf && !z;
      4'h9: return !cf || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Bench plays the alu block combinationally
  always_comb begin
    alu_out        = alu_eval(bus.alu_opcode, bus.alu_operand1, bus.alu_operand2,
                              bus.alu_carry_in, v_junk);
    bus.alu_n      = alu_out[35];
    bus.alu_z      = alu_out[34];
    bus.alu_c      = alu_out[33];
    bus.alu_v      = alu_out[32];
    bus.alu_result = alu_out[31:0];
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Whole-instruction prediction: one record per cycle from handshake to retire
  task automatic predict(input logic [31:0] w);
    exp_t        d, x, b;
    bit          ill, run, logical;
    logic [31:0] imm, op2;
    int          amt;
    logic [35:0] r;
    logic [3:0]  opc;
    opc = w[24:21];
    ill = (w[27:26] != 2'b00) || (w[31:28] == 4'hF) ||
          (!w[25] && (w[11:4] != 8'h0)) || ((opc >= 4'h8) && (opc <= 4'hB) && !w[20]);
    run = !ill && cond_holds(w[31:28], m_cpsr);
    logical = !((opc >= 4'h2 && opc <= 4'h7) || opc == 4'hA || opc == 4'hB);
    imm = {24'h0, w[7:0]};
    amt = 2 * int'(w[11:8]);
    op2 = w[25] ? ((amt == 0) ? imm : ((imm >> amt) | (imm << (32 - amt)))) : m_regs[w[3:0]];

    d = idle_rec();
    d.ready = 1'b0;
    q.push_back(d);
    if (run) begin
      x     = d;
      x.en  = 1'b1;
      x.op  = opc;
      x.op1 = m_regs[w[19:16]];
      x.op2 = op2;
      x.cin = logical ? ((w[25] && w[11:8] != 4'h0) ? op2[31] : m_cpsr[1]) : m_cpsr[1];
      x.fu  = w[20];
      r     = alu_eval(opc, x.op1, x.op2, x.cin, 1'b0);
      x.wr_rd    = !(opc >= 4'h8 && opc <= 4'hB);
      x.rd       = w[15:12];
      x.rd_val   = r[31:0];
      x.wr_cpsr  = w[20];
      x.cpsr_val = {r[35:33], logical ? m_cpsr[0] : r[32]};
      q.push_back(x);
    end
    b       = d;
    b.rv    = 1'b1;
    b.rexec = run;
    b.rill  = ill;
    q.push_back(b);
  endtask

  // Reference model advances on each clock edge; reset abandons the instruction
  initial begin
    for (int i = 0; i < 16; i++) m_regs[i] = 32'h0;
    m_cpsr = 4'h0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int i = 0; i < 16; i++) m_regs[i] = 32'h0;
        m_cpsr = 4'h0;
        q.delete();
      end else if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        if (e.wr_rd) m_regs[e.rd] = e.rd_val;
        if (e.wr_cpsr) m_cpsr = e.cpsr_val;
      end else if (bus.instr_valid) begin
        predict(bus.instr);
      end
    end
  end

  // Per-cycle compare of all DUT outputs against the model
  initial begin
    v_junk = 1'b0;
    forever begin
      exp_t e;
      @(negedge clk);
      e = (q.size() > 0) ? q[0] : idle_rec();
      checkOutput("instr_ready", bus.instr_ready, e.ready);
      checkOutput("alu_enable", bus.alu_enable, e.en);
      checkOutput("retire_valid", bus.retire_valid, e.rv);
      checkOutput("retire_executed", bus.retire_executed, e.rexec);
      checkOutput("illegal", bus.illegal, e.rill);
      if (e.en) begin
        checkOutput("alu_opcode", bus.alu_opcode, e.op);
        checkOutput("alu_operand1", bus.alu_operand1, e.op1);
        checkOutput("alu_operand2", bus.alu_operand2, e.op2);
        checkOutput("alu_carry_in", bus.alu_carry_in, e.cin);
        checkOutput("alu_flag_update", bus.alu_flag_update, e.fu);
      end
      checkOutput("cpsr_flags", bus.cpsr_flags, m_cpsr);
      checkOutput("dbg_data", bus.dbg_data, m_regs[bus.dbg_addr]);
      bus.dbg_addr = bus.dbg_addr + 4'd1;
      v_junk = 1'($urandom);
    end
  end

  // Event counters used by the directed checks
  initial begin
    en_cnt = 0; rv_cnt = 0; ex_cnt = 0; ill_cnt = 0;
    forever begin
      @(negedge clk);
      if (bus.alu_enable) en_cnt++;
      if (bus.retire_valid) rv_cnt++;
      if (bus.retire_valid && bus.retire_executed) ex_cnt++;
      if (bus.retire_valid && bus.illegal) ill_cnt++;
    end
  end

  // Offer one instruction and return cycles from handshake to the next ready
  task automatic applyStimulus(input logic [31:0] w, output int cycles);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) checkOutput("ready_wait", bus.instr_ready, 1);
    bus.instr       = w;
    bus.instr_valid = 1'b1;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    cycles = 1;
    while (!bus.instr_ready && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    #1;
  endtask

  task automatic runInstr(input string name, input logic [31:0] w, input int exp_cycles,
                          input int exp_en, input int exp_rv, input int exp_ex, input int exp_ill);
    int cyc, en0, rv0, ex0, ill0;
    en0 = en_cnt; rv0 = rv_cnt; ex0 = ex_cnt; ill0 = ill_cnt;
    applyStimulus(w, cyc);
    checkOutput({name, "_cycles"}, cyc, exp_cycles);
    checkOutput({name, "_en"}, en_cnt - en0, exp_en);
    checkOutput({name, "_retire"}, rv_cnt - rv0, exp_rv);
    checkOutput({name, "_exec"}, ex_cnt - ex0, exp_ex);
    checkOutput({name, "_illegal"}, ill_cnt - ill0, exp_ill);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(3) != 0) w[31:28] = 4'hE;
    if ($urandom_range(7) != 0) w[27:26] = 2'b00;
    if (!w[25] && $urandom_range(7) != 0) w[11:4] = 8'h00;
    if (w[24:23] == 2'b10 && $urandom_range(3) != 0) w[20] = 1'b1;
    return w;
  endfunction

  // Directed test-plan sequence, then randomized traffic with a mid-run reset
  initial begin
    int rv0;
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr = 32'h0;
    bus.dbg_addr = 4'h0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_ready", bus.instr_ready, 1);
    checkOutput("reset_alu_enable", bus.alu_enable, 0);
    checkOutput("reset_operand2", bus.alu_operand2, 0);
    checkOutput("reset_cpsr", bus.cpsr_flags, 0);
    rst_n = 1'b1;

    runInstr("mov_r1_5", 32'hE3A01005, 4, 1, 1, 1, 0);
    checkOutput("model_r1_5", m_regs[1], 32'h00000005);
    checkOutput("mov_cpsr", bus.cpsr_flags, 4'h0);

    runInstr("mvn_r1", 32'hE3E01102, 4, 1, 1, 1, 0);
    checkOutput("model_r1_7fff", m_regs[1], 32'h7FFFFFFF);
    runInstr("adds_r2", 32'hE0912001, 4, 1, 1, 1, 0);
    checkOutput("model_r2", m_regs[2], 32'hFFFFFFFE);
    checkOutput("adds_cpsr", bus.cpsr_flags, 4'b1001);

    runInstr("moveq", 32'h03A03001, 3, 0, 1, 0, 0);
    checkOutput("model_r3_0", m_regs[3], 32'h0);
    runInstr("movmi", 32'h43A03001, 4, 1, 1, 1, 0);
    checkOutput("model_r3_1", m_regs[3], 32'h1);

    runInstr("cmp_r1", 32'hE1510001, 4, 1, 1, 1, 0);
    checkOutput("cmp_cpsr", bus.cpsr_flags, 4'b0110);
    checkOutput("cmp_r1_kept", m_regs[1], 32'h7FFFFFFF);
    runInstr("movs_r4", 32'hE3B04102, 4, 1, 1, 1, 0);
    checkOutput("model_r4", m_regs[4], 32'h80000000);
    checkOutput("movs_cpsr", bus.cpsr_flags, 4'b1010);

    runInstr("ill_shift", 32'hE0912011, 3, 0, 1, 0, 1);
    runInstr("ill_cond", 32'hF3A01005, 3, 0, 1, 0, 1);
    checkOutput("ill_cpsr", bus.cpsr_flags, 4'b1010);

    // Reset while MOV r1,#5 is in EXEC
    rv0 = rv_cnt;
    @(negedge clk);
    bus.instr = 32'hE3A01005;
    bus.instr_valid = 1'b1;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("rst_in_exec", bus.alu_enable, 1);
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    checkOutput("rst_no_retire", rv_cnt - rv0, 0);
    checkOutput("rst_ready", bus.instr_ready, 1);
    checkOutput("rst_cpsr", bus.cpsr_flags, 0);
    checkOutput("rst_model_r1", m_regs[1], 32'h0);
    repeat (16) @(negedge clk);

    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      bus.instr_valid = ($urandom_range(2) != 0);
      bus.instr = rand_instr();
      if (i == 2000) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
      end
    end
    @(negedge clk);
    bus.instr_valid = 1'b0;
    repeat (20) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
